number_token_sniffer: RTL and testbench
=======================================

// Module: number_token_sniffer
// PURPOSE
//  Streaming ASCII scanner: extracts whitespace-delimited decimal numbers from a byte
//  stream, converts each to binary, classifies it short/long, emits one token per number.
//  Generalised successor of the fixed byte sniffer: parametrised value/length widths and
//  short/long threshold, valid/ready on both sides, overflow saturation, end-of-text flush.
//  Sits between the UART/byte source and the token store.
// PARAMETERS
//  VAL_W      32  width of binary value accumulator / out_value
//  LEN_W       5  width of digit counter / out_len (saturates at 2**LEN_W-1)
//  SHORT_MAX   4  numbers with digit count <= SHORT_MAX are short, else long
//  DROP_W     16  width of discarded-word counter
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  en         in   1       enable; 0 freezes input side (in_ready=0), output side still drains
//  in_valid   in   1       in_data valid
//  in_data    in   8       ASCII byte
//  in_last    in   1       end of text with this byte; terminates any open word after it
//  in_ready   out  1       byte accepted when in_valid && in_ready
//  out_valid  out  1       token valid
//  out_ready  in   1       token consumed when out_valid && out_ready
//  out_value  out  VAL_W   binary value of the number (saturated on overflow)
//  out_len    out  LEN_W   digit count incl. leading zeros (saturated)
//  out_long   out  1       1 = digit count > SHORT_MAX (uses unsaturated knowledge: sat count is long)
//  out_ovf    out  1       1 = value exceeded 2**VAL_W-1, out_value = all ones
//  drop_cnt   out  DROP_W  count of discarded non-numeric words, saturating at all ones
// BEHAVIOUR
//  - Reset: out_valid=0, out_value=0, out_len=0, out_long=0, out_ovf=0, drop_cnt=0, state GAP,
//    accumulators 0. Reset mid-word discards the partial word; no token, no drop count.
//  - Classes: digit 0x30-0x39; whitespace 0x20,0x09,0x0A,0x0D; everything else = other.
//  - in_ready = en && (!out_valid || out_ready). Output is a single registered slot.
//  - FSM on each accepted byte:
//    GAP : digit -> NUM (acc=d, cnt=1); other -> SKIP; whitespace -> GAP.
//    NUM : digit -> NUM (acc=acc*10+d, cnt=cnt+1 sat); whitespace -> emit, GAP;
//          other -> SKIP (number discarded, e.g. "12a").
//    SKIP: whitespace -> GAP, drop_cnt+1 (sat); else stay SKIP.
//  - in_last: after applying the byte, if state is NUM -> emit; if SKIP -> drop_cnt+1;
//    state returns to GAP. A whitespace byte with in_last behaves as plain whitespace.
//  - Emit: out_valid=1 and out_* loaded on the clock edge that accepts the terminating byte
//    (latency 1 cycle from acceptance). out_* held stable while out_valid && !out_ready.
//    Consume and new emit in same cycle: slot reloaded, out_valid stays 1.
//  - Overflow: computed at VAL_W+4 bits; if result > 2**VAL_W-1, acc sticks at all ones and
//    ovf flag sets for rest of the number. cnt saturates at 2**LEN_W-1 (out_long then 1).
//  - Accumulators cleared on entry to NUM; ovf cleared on entry to NUM.
//  - en=0: nothing accepted, FSM/accumulators hold; pending token still drains via out_ready.
//  - Back-pressure: while slot full and out_ready=0, in_ready=0; no byte lost or duplicated.
// TESTING
//  1 "42 7\n" all ready -> tokens (42,len2,long0,ovf0),(7,len1,long0); drop_cnt=0.
//  2 "00123456 " SHORT_MAX=4 -> token value 123456, len 8, long 1; "12a 5 " -> token 5 only,
//    drop_cnt=1.
//  3 VAL_W=8: "255 256 " -> (255,ovf0),(255,ovf1,len3); LEN_W=2: "12345 " -> len 3, long 1.
//  4 out_ready=0 for 10 cycles after first token of "1 2 3 " -> in_ready low while slot full,
//    tokens 1,2,3 delivered in order, values stable during stall.
//  5 "99" with in_last on second '9' -> token 99 one cycle later; "ab" + in_last -> drop_cnt+1.
//  6 rst pulsed mid "123" then "4 " -> single token 4; en=0 for 5 cycles mid-number -> no
//    change, number completes correctly after en=1.

Source files
------------

// File: rtl/number_token_sniffer.sv
// Streaming ASCII scanner: pulls whitespace-delimited decimal numbers out of a byte
// stream and emits one binary token per number through a single registered output slot.
module number_token_sniffer #(
   parameter int VAL_W     = 32,
   parameter int LEN_W     = 5,
   parameter int SHORT_MAX = 4,
   parameter int DROP_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [VAL_W-1:0]  out_value,
   output logic [LEN_W-1:0]  out_len,
   output logic              out_long,
   output logic              out_ovf,
   output logic [DROP_W-1:0] drop_cnt
);

   typedef enum logic [1:0] {GAP, NUM, SKIP} state_t;

   localparam logic [LEN_W-1:0] CNT_MAX = '1;

   state_t             state_q, state_d;
   logic [VAL_W-1:0]   acc_q, acc_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               sat_q, sat_d;
   logic               ovf_q, ovf_d;
   logic               emit, drop_inc, accept;
   logic               is_dig, is_ws, prod_ovf, long_d;
   logic [3:0]         dig;
   logic [VAL_W+3:0]   prod;

   logic               ov_q;
   logic [VAL_W-1:0]   val_q;
   logic [LEN_W-1:0]   len_q;
   logic               long_q, oovf_q;
   logic [DROP_W-1:0]  drop_q;

   assign is_dig   = (in_data >= 8'h30) && (in_data <= 8'h39);
   assign is_ws    = (in_data == 8'h20) || (in_data == 8'h09) ||
                     (in_data == 8'h0A) || (in_data == 8'h0D);
   assign dig      = in_data[3:0];
   // acc*10 + d, kept 4 bits wider so overflow out of VAL_W is visible
   assign prod     = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {{VAL_W{1'b0}}, dig};
   assign prod_ovf = |prod[VAL_W+3:VAL_W];
   // sat_d marks a digit count that ran past CNT_MAX, which is always long
   assign long_d   = sat_d || (int'(cnt_d) > SHORT_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= GAP;
         acc_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sat_d    = sat_q;
      ovf_d    = ovf_q;
      emit     = 1'b0;
      drop_inc = 1'b0;
      if (accept) begin
         case (state_q)
            GAP: begin
               if (is_dig) begin
                  state_d = NUM;
                  acc_d   = VAL_W'(dig);
                  cnt_d   = LEN_W'(1);
                  sat_d   = 1'b0;
                  ovf_d   = 1'b0;
               end else if (!is_ws) begin
                  state_d = SKIP;
               end
            end
            NUM: begin
               if (is_dig) begin
                  acc_d = (ovf_q || prod_ovf) ? '1 : prod[VAL_W-1:0];
                  ovf_d = ovf_q || prod_ovf;
                  if (cnt_q == CNT_MAX) sat_d = 1'b1;
                  else                  cnt_d = cnt_q + LEN_W'(1);
               end else if (is_ws) begin
                  emit    = 1'b1;
                  state_d = GAP;
               end else begin
                  state_d = SKIP;
               end
            end
            SKIP: begin
               if (is_ws) begin
                  drop_inc = 1'b1;
                  state_d  = GAP;
               end
            end
            default: state_d = GAP;
         endcase
         // end of text closes whatever word the byte left open
         if (in_last) begin
            if (state_d == NUM)       emit     = 1'b1;
            else if (state_d == SKIP) drop_inc = 1'b1;
            state_d = GAP;
         end
      end
   end

   always_comb begin
      in_ready  = en && (!ov_q || out_ready);
      accept    = in_valid && in_ready;
      out_valid = ov_q;
      out_value = val_q;
      out_len   = len_q;
      out_long  = long_q;
      out_ovf   = oovf_q;
      drop_cnt  = drop_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ov_q   <= 1'b0;
         val_q  <= '0;
         len_q  <= '0;
         long_q <= 1'b0;
         oovf_q <= 1'b0;
         drop_q <= '0;
      end else begin
         if (emit) begin
            ov_q   <= 1'b1;
            val_q  <= acc_d;
            len_q  <= cnt_d;
            long_q <= long_d;
            oovf_q <= ovf_d;
         end else if (out_ready) begin
            ov_q   <= 1'b0;
         end
         if (drop_inc && (drop_q != '1)) drop_q <= drop_q + DROP_W'(1);
      end
   end

endmodule

// File: tb/tb_number_token_sniffer.sv
// Bench for number_token_sniffer: a default instance plus a narrow (VAL_W=8, LEN_W=2) one,
// expected tokens queued as stimulus is driven and popped as tokens leave the DUT.
module tb_number_token_sniffer;

   typedef struct {
      logic [31:0] v;
      logic [4:0]  l;
      logic        lg;
      logic        ov;
   } tok_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b1;
   logic        sel = 1'b0;

   logic        ir0, ov0, lg0, of0;
   logic [31:0] val0;
   logic [4:0]  len0;
   logic [15:0] drop0;
   logic        ir1, ov1, lg1, of1;
   logic [7:0]  val1;
   logic [1:0]  len1;
   logic [15:0] drop1;
   logic        cur_rdy;

   int   vectors = 0;
   int   miscompares = 0;
   tok_t q[$];

   always #5 clk = ~clk;

   assign cur_rdy = sel ? ir1 : ir0;

   number_token_sniffer u0 (
      .clk(clk), .rst(rst), .en(en),
      .in_valid(in_valid && !sel), .in_data(in_data), .in_last(in_last), .in_ready(ir0),
      .out_valid(ov0), .out_ready(out_ready), .out_value(val0), .out_len(len0),
      .out_long(lg0), .out_ovf(of0), .drop_cnt(drop0));

   number_token_sniffer #(.VAL_W(8), .LEN_W(2), .SHORT_MAX(4), .DROP_W(16)) u1 (
      .clk(clk), .rst(rst), .en(en),
      .in_valid(in_valid && sel), .in_data(in_data), .in_last(in_last), .in_ready(ir1),
      .out_valid(ov1), .out_ready(out_ready), .out_value(val1), .out_len(len1),
      .out_long(lg1), .out_ovf(of1), .drop_cnt(drop1));

   task automatic expect_tok(input int v, input int l, input bit lg, input bit ov);
      tok_t t;
      t.v = v; t.l = l[4:0]; t.lg = lg; t.ov = ov;
      q.push_back(t);
   endtask

   task automatic monitor_step();
      tok_t g, e;
      @(negedge clk);
      if (!rst && out_ready && (ov0 || ov1)) begin
         if (ov0) begin g.v = val0; g.l = len0; g.lg = lg0; g.ov = of0; end
         else begin g.v = {24'b0, val1}; g.l = {3'b0, len1}; g.lg = lg1; g.ov = of1; end
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL token_unexpected got v=%0d l=%0d long=%0b ovf=%0b", g.v, g.l, g.lg, g.ov);
         end else begin
            e = q.pop_front();
            if (g.v !== e.v || g.l !== e.l || g.lg !== e.lg || g.ov !== e.ov) begin
               miscompares++;
               $display("FAIL token got v=%0d l=%0d long=%0b ovf=%0b want v=%0d l=%0d long=%0b ovf=%0b",
                        g.v, g.l, g.lg, g.ov, e.v, e.l, e.lg, e.ov);
            end
         end
      end
   endtask

   task automatic send(input logic [7:0] b, input bit last);
      int n = 0;
      in_valid = 1'b1; in_data = b; in_last = last;
      @(negedge clk);
      while (!cur_rdy && n < 200) begin @(negedge clk); n++; end
      if (!cur_rdy) begin
         vectors++; miscompares++;
         $display("FAIL send_timeout byte=%h in_ready=%b want 1", b, cur_rdy);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic send_str(input string s, input bit last);
      for (int i = 0; i < s.len(); i++) send(s[i], last && (i == s.len() - 1));
   endtask

   task automatic wait_drain();
      int n = 0;
      while (q.size() != 0 && n < 300) begin @(posedge clk); n++; end
      #1;
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain_timeout pending=%0d want 0", q.size());
         q.delete();
      end
   endtask

   task automatic check_drop(input string name, input logic [15:0] got, input int want);
      vectors++;
      if (got !== want[15:0]) begin
         miscompares++;
         $display("FAIL %s drop_cnt=%0d want %0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({ov0, val0, len0, lg0, of0, drop0} !== '0) begin
         miscompares++;
         $display("FAIL reset_u0 got v=%b val=%0d len=%0d drop=%0d want all 0", ov0, val0, len0, drop0);
      end
      vectors++;
      if ({ov1, val1, len1, lg1, of1, drop1} !== '0) begin
         miscompares++;
         $display("FAIL reset_u1 got v=%b val=%0d len=%0d drop=%0d want all 0", ov1, val1, len1, drop1);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      expect_tok(42, 2, 0, 0);
      expect_tok(7, 1, 0, 0);
      send_str("42 7\n", 0);
      wait_drain();
      check_drop("basic", drop0, 0);
   endtask

   task automatic test_long_and_skip();
      expect_tok(123456, 8, 1, 0);
      send_str("00123456 ", 0);
      expect_tok(5, 1, 0, 0);
      send_str("12a 5 ", 0);
      wait_drain();
      check_drop("skip", drop0, 1);
   endtask

   task automatic test_overflow();
      sel = 1'b1;
      expect_tok(255, 3, 0, 0);
      expect_tok(255, 3, 0, 1);
      send_str("255 256 ", 0);
      expect_tok(255, 3, 1, 1);
      send_str("12345 ", 0);
      wait_drain();
      check_drop("ovf", drop1, 0);
      sel = 1'b0;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      expect_tok(1, 1, 0, 0);
      expect_tok(2, 1, 0, 0);
      expect_tok(3, 1, 0, 0);
      send_str("1 ", 0);
      in_valid = 1'b1; in_data = "2"; in_last = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if (ov0 !== 1'b1 || val0 !== 32'd1 || ir0 !== 1'b0) begin
            miscompares++;
            $display("FAIL stall cyc=%0d valid=%b val=%0d in_ready=%b want 1,1,0", i, ov0, val0, ir0);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b0;
      send_str("2 3 ", 0);
      wait_drain();
   endtask

   task automatic test_last();
      expect_tok(99, 2, 0, 0);
      send_str("99", 1);
      vectors++;
      if (ov0 !== 1'b1 || val0 !== 32'd99) begin
         miscompares++;
         $display("FAIL last_latency valid=%b val=%0d want 1,99", ov0, val0);
      end
      wait_drain();
      send_str("ab", 1);
      @(posedge clk); #1;
      check_drop("last_drop", drop0, 2);
   endtask

   task automatic test_reset_and_enable();
      send_str("123", 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      expect_tok(4, 1, 0, 0);
      send_str("4 ", 0);
      wait_drain();
      check_drop("after_rst", drop0, 0);
      send_str("5", 0);
      en = 1'b0;
      in_valid = 1'b1; in_data = "7"; in_last = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if (ir0 !== 1'b0 || ov0 !== 1'b0) begin
            miscompares++;
            $display("FAIL en_freeze cyc=%0d in_ready=%b valid=%b want 0,0", i, ir0, ov0);
         end
      end
      @(posedge clk); #1;
      en = 1'b1; in_valid = 1'b0;
      expect_tok(56, 2, 0, 0);
      send_str("6 ", 0);
      wait_drain();
   endtask

   initial begin
      fork
         forever monitor_step();
      join_none
      test_reset();
      test_basic();
      test_long_and_skip();
      test_overflow();
      test_back_to_back();
      test_last();
      test_reset_and_enable();
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
